// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state encoding, opcode/funct constants, ALU codes
// and the R-type funct decoder used by the multi-cycle control FSM.
package multicycle_ctrl_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
    } funct_dec_t;

    // Maps an R-type funct field to its ALU code; valid=0 marks an unknown funct
    function automatic funct_dec_t decodeFunct(input logic [5:0] funct);
        funct_dec_t d;
        d.valid = 1'b1;
        d.op    = ALU_ADD;
        case (funct)
            FN_ADD:  d.op = ALU_ADD;
            FN_SUB:  d.op = ALU_SUB;
            FN_AND:  d.op = ALU_AND;
            FN_OR:   d.op = ALU_OR;
            FN_SLT:  d.op = ALU_SLT;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait.sv
// wait_counter: counts wait cycles inside FETCH/MEM; done when the count
// reaches the configured limit, load restarts the count at zero.
module wait_counter
    import multicycle_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [WAIT_CNT_W-1:0] i_limit,
    output logic                  o_done
);

    logic [WAIT_CNT_W-1:0] r_count;

    // Restart at zero on load, otherwise advance one wait cycle per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == i_limit);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle MIPS-like datapath.
// Optional retired-instruction counter, enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_en,
    output logic        ir_en,
    output logic        addr_sel,
    output logic        mem_we,
    output logic        reg_we,
    output logic        branch,
    output logic        jump,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT);

    state_t     r_state;
    state_t     w_nextState;
    logic       r_illegal;
    logic       w_illegalNow;
    logic       w_waitDone;
    logic       w_cntLoad;
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    funct_dec_t w_functDec;
    logic       w_unusedInstrBits;

    assign w_opcode          = instr[31:26];
    assign w_funct           = instr[5:0];
    assign w_functDec        = decodeFunct(w_funct);
    assign w_unusedInstrBits = ^instr[25:6];

    // The counter only runs inside FETCH/MEM and restarts once the wait completes
    assign w_cntLoad = !((r_state == ST_FETCH) || (r_state == ST_MEM)) || w_waitDone;

    wait_counter u_waitCounter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cntLoad),
        .i_limit (WAIT_LIMIT),
        .o_done  (w_waitDone)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control outputs; reset forces every output low immediately
    always_comb begin
        w_nextState  = r_state;
        w_illegalNow = 1'b0;
        pc_en        = 1'b0;
        ir_en        = 1'b0;
        addr_sel     = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        alu_op       = ALU_ADD;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_waitDone) begin
                    pc_en       = 1'b1;
                    ir_en       = 1'b1;
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_RTYPE: begin
                        if (w_functDec.valid) begin
                            w_nextState = ST_EXEC;
                        end else begin
                            w_illegalNow = 1'b1;
                            w_nextState  = ST_FETCH;
                        end
                    end
                    OP_LW, OP_SW, OP_BEQ: w_nextState = ST_EXEC;
                    OP_J: begin
                        jump        = 1'b1;
                        pc_en       = 1'b1;
                        w_nextState = ST_FETCH;
                    end
                    OP_HALT: w_nextState = ST_HALT;
                    default: begin
                        w_illegalNow = 1'b1;
                        w_nextState  = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                case (w_opcode)
                    OP_RTYPE: begin
                        alu_op      = w_functDec.op;
                        w_nextState = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_op      = ALU_ADD;
                        w_nextState = ST_MEM;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        if (zero) begin
                            branch = 1'b1;
                            pc_en  = 1'b1;
                        end
                        w_nextState = ST_FETCH;
                    end
                    default: w_nextState = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                if (w_waitDone) begin
                    if (w_opcode == OP_SW) begin
                        mem_we      = 1'b1;
                        w_nextState = ST_FETCH;
                    end else begin
                        w_nextState = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we      = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_nextState = ST_FETCH;
        endcase
        if (rst) begin
            pc_en    = 1'b0;
            ir_en    = 1'b0;
            addr_sel = 1'b0;
            mem_we   = 1'b0;
            reg_we   = 1'b0;
            branch   = 1'b0;
            jump     = 1'b0;
            alu_op   = ALU_ADD;
            halted   = 1'b0;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegalNow) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (w_nextState == ST_FETCH) && !w_illegalNow &&
                      ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                       (r_state == ST_MEM) || (r_state == ST_WB));

    // Count completed instructions; wraps naturally at 32 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of the control FSM
// (MEM_WAIT=1) plus a reset-during-MEM sequence on a MEM_WAIT=3 instance.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        logic [10:0] expOut;
        logic        expIllegal;
        logic [31:0] expRetired;
    } vec_t;

    logic        clk;
    logic        rst1, rst2;
    logic [31:0] instr1, instr2;
    logic        zero1, zero2;
    logic        pcEn1, irEn1, addrSel1, memWe1, regWe1, branch1, jump1, halted1, illegal1;
    logic        pcEn2, irEn2, addrSel2, memWe2, regWe2, branch2, jump2, halted2, illegal2;
    logic [2:0]  aluOp1, aluOp2;
    logic [31:0] retired1, retired2;
    logic [10:0] out1, out2;

    vec_t        vecQ[$];
    int          retCount;
    logic        illSticky;
    int          nCompared;
    int          nMismatched;
    logic        sawMemWe2 = 1'b0;

    assign out1 = {pcEn1, irEn1, addrSel1, memWe1, regWe1, branch1, jump1, aluOp1, halted1};
    assign out2 = {pcEn2, irEn2, addrSel2, memWe2, regWe2, branch2, jump2, aluOp2, halted2};

    multicycle_ctrl #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst1), .instr(instr1), .zero(zero1),
        .pc_en(pcEn1), .ir_en(irEn1), .addr_sel(addrSel1), .mem_we(memWe1),
        .reg_we(regWe1), .branch(branch1), .jump(jump1), .alu_op(aluOp1),
        .halted(halted1), .illegal(illegal1), .retired(retired1)
    );

    multicycle_ctrl #(.MEM_WAIT(3)) dut2 (
        .clk(clk), .rst(rst2), .instr(instr2), .zero(zero2),
        .pc_en(pcEn2), .ir_en(irEn2), .addr_sel(addrSel2), .mem_we(memWe2),
        .reg_we(regWe2), .branch(branch2), .jump(jump2), .alu_op(aluOp2),
        .halted(halted2), .illegal(illegal2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge memWe2) sawMemWe2 = 1'b1;

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'hABCDE, fn};
    endfunction

    function automatic logic [10:0] mkExp(input logic pc, input logic ir, input logic as,
                                          input logic mw, input logic rw, input logic br,
                                          input logic jp, input logic [2:0] alu, input logic h);
        return {pc, ir, as, mw, rw, br, jp, alu, h};
    endfunction

    task automatic pushCycle(input string nm, input logic [31:0] ins, input logic z,
                             input logic [10:0] e);
        vec_t v;
        v.name       = nm;
        v.instr      = ins;
        v.zero       = z;
        v.expOut     = e;
        v.expIllegal = illSticky;
        v.expRetired = PERF ? 32'(retCount) : 32'd0;
        vecQ.push_back(v);
    endtask

    task automatic addFetch(input string nm, input logic [31:0] ins, input logic z);
        pushCycle(nm, ins, z, 11'd0);
        pushCycle(nm, ins, z, mkExp(1, 1, 0, 0, 0, 0, 0, 3'b000, 0));
    endtask

    task automatic addRtype(input string nm, input logic [5:0] fn, input logic [2:0] alu);
        logic [31:0] ins;
        ins = mkInstr(6'h00, fn);
        addFetch(nm, ins, 1'b1);
        pushCycle(nm, ins, 1'b1, 11'd0);
        pushCycle(nm, ins, 1'b1, mkExp(0, 0, 0, 0, 0, 0, 0, alu, 0));
        pushCycle(nm, ins, 1'b1, mkExp(0, 0, 0, 0, 1, 0, 0, 3'b000, 0));
        retCount++;
    endtask

    task automatic buildTable();
        logic [31:0] ins;
        addRtype("add", 6'h20, 3'b000);
        addRtype("sub", 6'h22, 3'b001);
        addRtype("and", 6'h24, 3'b010);
        addRtype("or",  6'h25, 3'b011);
        addRtype("slt", 6'h2A, 3'b100);
        ins = mkInstr(6'h23, 6'h00);
        addFetch("lw", ins, 1'b0);
        pushCycle("lw", ins, 1'b0, 11'd0);
        pushCycle("lw", ins, 1'b0, 11'd0);
        pushCycle("lw", ins, 1'b0, mkExp(0, 0, 1, 0, 0, 0, 0, 3'b000, 0));
        pushCycle("lw", ins, 1'b0, mkExp(0, 0, 1, 0, 0, 0, 0, 3'b000, 0));
        pushCycle("lw", ins, 1'b0, mkExp(0, 0, 0, 0, 1, 0, 0, 3'b000, 0));
        retCount++;
        ins = mkInstr(6'h2B, 6'h00);
        addFetch("sw", ins, 1'b0);
        pushCycle("sw", ins, 1'b0, 11'd0);
        pushCycle("sw", ins, 1'b0, 11'd0);
        pushCycle("sw", ins, 1'b0, mkExp(0, 0, 1, 0, 0, 0, 0, 3'b000, 0));
        pushCycle("sw", ins, 1'b0, mkExp(0, 0, 1, 1, 0, 0, 0, 3'b000, 0));
        retCount++;
        ins = mkInstr(6'h04, 6'h00);
        addFetch("beq_t", ins, 1'b1);
        pushCycle("beq_t", ins, 1'b1, 11'd0);
        pushCycle("beq_t", ins, 1'b1, mkExp(1, 0, 0, 0, 0, 1, 0, 3'b001, 0));
        retCount++;
        addFetch("beq_n", ins, 1'b0);
        pushCycle("beq_n", ins, 1'b0, 11'd0);
        pushCycle("beq_n", ins, 1'b0, mkExp(0, 0, 0, 0, 0, 0, 0, 3'b001, 0));
        retCount++;
        ins = mkInstr(6'h02, 6'h00);
        addFetch("j", ins, 1'b1);
        pushCycle("j", ins, 1'b1, mkExp(1, 0, 0, 0, 0, 0, 1, 3'b000, 0));
        retCount++;
        ins = mkInstr(6'h15, 6'h20);
        addFetch("ill_op", ins, 1'b0);
        pushCycle("ill_op", ins, 1'b0, 11'd0);
        illSticky = 1'b1;
        ins = mkInstr(6'h00, 6'h3F);
        addFetch("ill_fn", ins, 1'b0);
        pushCycle("ill_fn", ins, 1'b0, 11'd0);
        addRtype("add2", 6'h20, 3'b000);
        ins = mkInstr(6'h3F, 6'h00);
        addFetch("halt", ins, 1'b0);
        pushCycle("halt", ins, 1'b0, 11'd0);
        for (int k = 0; k < 20; k++) begin
            pushCycle("halted", ins, 1'b0, mkExp(0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        instr1 = v.instr;
        zero1  = v.zero;
        #1;
    endtask

    task automatic checkOutput(input string nm, input int cyc, input logic [31:0] act,
                               input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        rst1        = 1'b1;
        rst2        = 1'b1;
        instr1      = 32'd0;
        instr2      = 32'd0;
        zero1       = 1'b0;
        zero2       = 1'b0;
        nCompared   = 0;
        nMismatched = 0;
        retCount    = 0;
        illSticky   = 1'b0;
        buildTable();

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out1", 0, {21'd0, out1}, 32'd0);
        checkOutput("rst_ill1", 0, {31'd0, illegal1}, 32'd0);
        checkOutput("rst_ret1", 0, retired1, 32'd0);
        checkOutput("rst_out2", 0, {21'd0, out2}, 32'd0);

        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(vecQ[i]);
            checkOutput({vecQ[i].name, "_out"}, i + 1, {21'd0, out1}, {21'd0, vecQ[i].expOut});
            checkOutput({vecQ[i].name, "_ill"}, i + 1, {31'd0, illegal1}, {31'd0, vecQ[i].expIllegal});
            checkOutput({vecQ[i].name, "_ret"}, i + 1, retired1, vecQ[i].expRetired);
            @(negedge clk);
        end

        #2 rst1 = 1'b1;
        #1;
        checkOutput("halt_rst_out", 0, {21'd0, out1}, 32'd0);
        checkOutput("halt_rst_ill", 0, {31'd0, illegal1}, 32'd0);
        checkOutput("halt_rst_ret", 0, retired1, 32'd0);

        @(negedge clk);
        instr2 = mkInstr(6'h2B, 6'h00);
        rst2   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            checkOutput("swm3_out", c, {21'd0, out2},
                        (c == 4) ? {21'd0, mkExp(1, 1, 0, 0, 0, 0, 0, 3'b000, 0)} :
                        (c >= 7) ? {21'd0, mkExp(0, 0, 1, 0, 0, 0, 0, 3'b000, 0)} : 32'd0);
            if (c < 8) @(negedge clk);
        end
        #1 rst2 = 1'b1;
        #1;
        checkOutput("swm3_rst_out", 8, {21'd0, out2}, 32'd0);
        checkOutput("swm3_rst_ill", 8, {31'd0, illegal2}, 32'd0);
        checkOutput("swm3_rst_ret", 8, retired2, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("swm3_held_out", 9, {21'd0, out2}, 32'd0);
        rst2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                @(negedge clk);
                #1;
            end else begin
                #1;
            end
            checkOutput("swm3_refetch", k, {21'd0, out2},
                        (k == 4) ? {21'd0, mkExp(1, 1, 0, 0, 0, 0, 0, 3'b000, 0)} : 32'd0);
        end
        checkOutput("swm3_no_memwe", 0, {31'd0, sawMemWe2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, extra memory wait cycles per access (0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr  input  32  instruction register contents; opcode [31:26], funct [5:0].
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port pc_en  output  1  PC load enable (PC+4, branch or jump target).
REQ-007 SHALL have port ir_en  output  1  instruction register load enable.
REQ-008 SHALL have port addr_sel  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 SHALL have ports mem_we, reg_we, branch, jump  output  1 each  memory write, register-file write, branch-taken PC select, jump PC select.
REQ-010 SHALL have port alu_op  output  3  ALU operation code.
REQ-011 SHALL have ports halted and illegal  output  1 each  HALT reached; sticky illegal-instruction flag.
REQ-012 SHALL have port retired  output  32  count of retired instructions.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 FETCH SHALL last MEM_WAIT+1 cycles with addr_sel=0; pc_en and ir_en SHALL be 1 only in its last cycle; next state DECODE.
REQ-015 R-type (opcode 0x00) SHALL sequence DECODE->EXEC->WB->FETCH, with reg_we=1 for the single WB cycle.
REQ-016 LW (0x23) SHALL sequence DECODE->EXEC->MEM->WB->FETCH; MEM SHALL last MEM_WAIT+1 cycles with addr_sel=1.
REQ-017 SW (0x2B) SHALL sequence DECODE->EXEC->MEM->FETCH; mem_we SHALL be 1 only in the last MEM cycle.
REQ-018 BEQ (0x04) SHALL sequence DECODE->EXEC->FETCH with alu_op=SUB in EXEC; branch and pc_en SHALL both be 1 in EXEC only when zero=1.
REQ-019 J (0x02) SHALL assert jump and pc_en in DECODE, then return to FETCH.
REQ-020 HALT (0x3F) SHALL move DECODE->HALT; halted SHALL be 1 in HALT, and HALT SHALL be left only by reset.
REQ-021 R-type alu_op SHALL decode funct 0x20->ADD(000), 0x22->SUB(001), 0x24->AND(010), 0x25->OR(011), 0x2A->SLT(100); LW/SW EXEC SHALL use ADD.
REQ-022 An unknown opcode or R-type funct SHALL set illegal (sticky until reset), assert no write, and return DECODE->FETCH.
REQ-023 All enables SHALL be 0 in any state/cycle not listed above; at most one of mem_we and reg_we SHALL be 1 in a cycle.
REQ-024 With MEM_WAIT=1, cycle counts SHALL be: R 5, LW 7, SW 6, BEQ 4, J 3.

Reset
REQ-025 rst SHALL force, without waiting for clk: state FETCH, wait counter 0, every output 0, illegal 0, retired 0.
REQ-026 Reset during MEM SHALL drop mem_we immediately, so no write occurs; the first cycle after release SHALL be FETCH cycle 0.

Configuration
REQ-027 With MULTICYCLE_CTRL_PERF_EN defined, retired SHALL increment by 1 on each transition into FETCH from DECODE, EXEC, MEM or WB, except after illegal instructions, and SHALL wrap 0xFFFFFFFF->0.
REQ-028 Without MULTICYCLE_CTRL_PERF_EN, retired SHALL be constant 0 and no counter SHALL be synthesized.

Structure
REQ-029 Package multicycle_ctrl_pkg SHALL hold the state encoding, the opcode and funct constants, and the alu_op codes.
REQ-030 Wait-state counting for FETCH and MEM SHALL be one sub-module, wait_counter (load, done, count width 4).

Verification
REQ-031 Reset then R-type ADD (0x00, funct 0x20), MEM_WAIT=1 -> ir_en/pc_en at cycle 2, alu_op=000 in EXEC, reg_we at cycle 5, retired=1.
REQ-032 LW then SW -> addr_sel=1 for 2 MEM cycles each; reg_we at LW cycle 7; mem_we exactly 1 cycle at SW cycle 6; retired=2.
REQ-033 BEQ with zero=1, then BEQ with zero=0 -> branch+pc_en in cycle 4 for the first only; both instructions take 4 cycles.
REQ-034 Opcode 0x15, then funct 0x3F -> illegal=1 and stays 1, no writes, retired unchanged, fetch resumes.
REQ-035 HALT -> halted=1 and held for 20 cycles; then rst pulse mid-SW MEM with MEM_WAIT=3 -> mem_we never 1, all outputs 0, FETCH restarts.
